// File: rtl/dti_tniu_req_arb_packer_pkg.sv
// Shared widths, flit layout and arbiter FSM states for the TNIU request packer.
// Pure type/constant package: no latency, no backpressure.
// Payload packs {data, keep} with keep in the LSBs.
package dti_tniu_req_arb_packer_pkg;

    localparam int CUSTOM_DATA_WIDTH = 32;
    localparam int CUSTOM_KEEP_WIDTH = CUSTOM_DATA_WIDTH / 8;
    localparam int TBU_NUM_WIDTH     = 4;
    localparam int PAYLOAD_WIDTH     = CUSTOM_DATA_WIDTH + CUSTOM_KEEP_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } dti_arb_state_e;

    typedef struct packed {
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [TBU_NUM_WIDTH-1:0] srcid;
        logic [TBU_NUM_WIDTH-1:0] tgtid;
        logic                     qos;
        logic                     last;
    } dti_req_flit_t;

    // Source id wraps modulo 2^TBU_NUM_WIDTH by truncation.
    function automatic logic [TBU_NUM_WIDTH-1:0] src_id(input int base, input int idx);
        return TBU_NUM_WIDTH'(base + idx);
    endfunction

endpackage

// File: rtl/dti_rr_arb.sv
// Round-robin pick: first asserted request at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is taken.
module dti_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic [N-1:0]         gnt_oh
);
    localparam int PW = $clog2(N);

    int          k;
    logic [PW-1:0] k_idx;

    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        k       = 0;
        k_idx   = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            k_idx = PW'(k);
            if (!any && req[k_idx]) begin
                any           = 1'b1;
                gnt_idx       = k_idx;
                gnt_oh[k_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dti_tniu_req_arb_packer.sv
// Round-robin message arbiter + flit packer feeding the TNIU async REQ FIFO.
// Latency: 1 cycle from beat accept to req_valid; 1 flit/cycle while req_ready.
// Backpressure: s_ready follows the output register load; req_threshold blocks new messages only.
module dti_tniu_req_arb_packer
    import dti_tniu_req_arb_packer_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SRC_ID_BASE = 0,
    parameter int MAX_BEATS   = 16
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [NUM_SRC-1:0]                               s_valid,
    input  logic [NUM_SRC-1:0][CUSTOM_DATA_WIDTH-1:0]        s_data,
    input  logic [NUM_SRC-1:0][CUSTOM_KEEP_WIDTH-1:0]        s_keep,
    input  logic [NUM_SRC-1:0]                               s_last,
    input  logic [NUM_SRC-1:0][TBU_NUM_WIDTH-1:0]            s_tgtid,
    output logic [NUM_SRC-1:0]                               s_ready,
    output logic                                             req_valid,
    output logic [PAYLOAD_WIDTH-1:0]                         req_payload,
    output logic                                             req_last,
    output logic [TBU_NUM_WIDTH-1:0]                         req_srcid,
    output logic [TBU_NUM_WIDTH-1:0]                         req_tgtid,
    output logic                                             req_qos,
    input  logic                                             req_threshold,
    input  logic                                             req_ready,
    output logic                                             err_len
);
    localparam int PW = $clog2(NUM_SRC);
    localparam int BW = $clog2(MAX_BEATS);

    dti_arb_state_e state;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  gnt;
    logic [BW-1:0]  beat_cnt;
    logic [TBU_NUM_WIDTH-1:0] tgt_q;
    dti_req_flit_t  flit_q;
    logic           valid_q;
    logic           err_q;

    logic           pick_any;
    logic [PW-1:0]  pick_idx;
    logic [NUM_SRC-1:0] pick_oh;

    logic           load;
    logic [PW-1:0]  sel;
    logic           acc;
    logic           emit;
    logic           beat_last;
    logic           at_max;
    logic [PW-1:0]  nxt_ptr;

    dti_rr_arb #(.N(NUM_SRC)) u_arb (
        .req     (s_valid),
        .ptr     (rr_ptr),
        .any     (pick_any),
        .gnt_idx (pick_idx),
        .gnt_oh  (pick_oh)
    );

    assign load      = !valid_q || req_ready;
    assign beat_last = s_last[sel];
    assign at_max    = (beat_cnt == BW'(MAX_BEATS - 1));
    assign nxt_ptr   = (sel == PW'(NUM_SRC - 1)) ? '0 : sel + PW'(1);

    always_comb begin
        s_ready = '0;
        sel     = gnt;
        case (state)
            IDLE: begin
                sel = pick_idx;
                if (!req_threshold && pick_any && load) begin
                    s_ready = pick_oh;
                end
            end
            PASS:    s_ready[gnt] = load;
            // Truncated tail is swallowed regardless of the output stage.
            DRAIN:   s_ready[gnt] = 1'b1;
            default: s_ready = '0;
        endcase
        if (rst) begin
            s_ready = '0;
        end
        acc  = |(s_ready & s_valid);
        emit = acc && (state != DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt        <= '0;
            beat_cnt   <= '0;
            tgt_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            flit_q     <= '0;
            flit_q.qos <= 1'b1;
        end else begin
            err_q <= 1'b0;
            if (load) begin
                valid_q <= emit;
            end
            if (emit) begin
                flit_q.payload <= {s_data[sel], s_keep[sel]};
                flit_q.srcid   <= src_id(SRC_ID_BASE, int'(sel));
                flit_q.tgtid   <= (state == IDLE) ? s_tgtid[sel] : tgt_q;
                flit_q.qos     <= 1'b1;
                flit_q.last    <= beat_last || ((state == PASS) && at_max);
            end
            case (state)
                IDLE: begin
                    if (acc) begin
                        gnt   <= sel;
                        tgt_q <= s_tgtid[sel];
                        if (beat_last) begin
                            rr_ptr   <= nxt_ptr;
                            beat_cnt <= '0;
                        end else begin
                            state    <= PASS;
                            beat_cnt <= BW'(1);
                        end
                    end
                end
                PASS: begin
                    if (acc) begin
                        if (beat_last) begin
                            rr_ptr   <= nxt_ptr;
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else if (at_max) begin
                            err_q <= 1'b1;
                            state <= DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (acc && beat_last) begin
                        rr_ptr   <= nxt_ptr;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_valid   = valid_q;
    assign req_payload = flit_q.payload;
    assign req_last    = flit_q.last;
    assign req_srcid   = flit_q.srcid;
    assign req_tgtid   = flit_q.tgtid;
    assign req_qos     = flit_q.qos;
    assign err_len     = err_q;

endmodule

// File: tb/tb_dti_tniu_req_arb_packer.sv
// Randomized + directed bench for the request packer against a message-level reference model.
module tb_dti_tniu_req_arb_packer;
    import dti_tniu_req_arb_packer_pkg::*;

    localparam int NSRC = 4;
    localparam int BASE = 14;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NSRC-1:0] s_valid;
    logic [NSRC-1:0][CUSTOM_DATA_WIDTH-1:0] s_data;
    logic [NSRC-1:0][CUSTOM_KEEP_WIDTH-1:0] s_keep;
    logic [NSRC-1:0] s_last;
    logic [NSRC-1:0][TBU_NUM_WIDTH-1:0] s_tgtid;
    logic [NSRC-1:0] s_ready;
    logic req_valid, req_last, req_qos, req_threshold, req_ready, err_len;
    logic [PAYLOAD_WIDTH-1:0] req_payload;
    logic [TBU_NUM_WIDTH-1:0] req_srcid, req_tgtid;

    dti_tniu_req_arb_packer #(.NUM_SRC(NSRC), .SRC_ID_BASE(BASE), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep),
        .s_last(s_last), .s_tgtid(s_tgtid), .s_ready(s_ready), .req_valid(req_valid),
        .req_payload(req_payload), .req_last(req_last), .req_srcid(req_srcid),
        .req_tgtid(req_tgtid), .req_qos(req_qos), .req_threshold(req_threshold),
        .req_ready(req_ready), .err_len(err_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  tgtid;
        logic        last;
    } beat_t;

    typedef struct {
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [3:0] srcid;
        logic [3:0] tgtid;
        logic       last;
    } eflit_t;

    typedef struct {
        int          cyc;
        logic [3:0]  srcid;
        logic [3:0]  tgtid;
        logic [31:0] data;
        logic        last;
    } obs_t;

    beat_t  pq[NSRC][$];
    int     sent[NSRC];
    eflit_t exp_q[$];
    obs_t   flog[$];
    int     glog_port[$];
    int     glog_cyc[$];

    int active = -1;
    int nb = 0;
    int mptr = 0;
    logic [3:0] mtgt = '0;
    logic err_exp = 1'b0;
    int err_seen = 0;
    int rdy_seen = 0;
    int cyc = 0;
    int gap_pct = 0;
    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic add_msg(input int p, input int len, input logic [31:0] base, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = rnd ? 32'($urandom) : base + 32'(i);
            b.keep  = rnd ? 4'($urandom) : 4'(i);
            b.tgtid = rnd ? 4'($urandom) : 4'(i + 1);
            b.last  = (i == len - 1);
            pq[p].push_back(b);
        end
    endtask

    function automatic bit busy();
        for (int p = 0; p < NSRC; p++) if (pq[p].size() != 0) return 1'b1;
        return (exp_q.size() != 0) || (active >= 0);
    endfunction

    task automatic push_exp(input int p, input beat_t b, input logic last);
        eflit_t e;
        e.payload = {b.data, b.keep};
        e.srcid   = 4'((BASE + p) % 16);
        e.tgtid   = mtgt;
        e.last    = last;
        exp_q.push_back(e);
    endtask

    // Message-level model: grant order, truncation, per-message tgtid.
    task automatic model_accept(input int p, input beat_t b);
        if (active < 0) begin
            active = p;
            nb     = 1;
            mtgt   = b.tgtid;
            glog_port.push_back(p);
            glog_cyc.push_back(cyc);
            push_exp(p, b, b.last);
        end else begin
            chk("interleave", 64'(p), 64'(active));
            if (nb < MAXB) begin
                nb++;
                push_exp(p, b, b.last || (nb == MAXB));
                if (nb == MAXB && !b.last) err_exp = 1'b1;
            end
        end
        if (b.last) begin
            active = -1;
            nb     = 0;
            mptr   = (p + 1) % NSRC;
        end
    endtask

    task automatic step();
        logic [NSRC-1:0] acc;
        logic [NSRC-1:0] exp_rdy;
        logic load;
        bit found;
        int q;
        obs_t o;
        beat_t b;
        @(negedge clk);
        cyc++;
        acc = s_valid & s_ready;
        if (|s_ready) rdy_seen++;
        if (rst) begin
            chk("rst_s_ready", 64'(s_ready), 64'(0));
            exp_q.delete();
            active = -1; nb = 0; mptr = 0; err_exp = 1'b0;
        end else begin
            load = (exp_q.size() == 0) || req_ready;
            chk("req_valid", 64'(req_valid), 64'(exp_q.size() != 0));
            chk("err_len", 64'(err_len), 64'(err_exp));
            if (err_len) err_seen++;
            err_exp = 1'b0;
            if (req_valid && exp_q.size() != 0) begin
                chk("payload", 64'(req_payload), 64'(exp_q[0].payload));
                chk("srcid", 64'(req_srcid), 64'(exp_q[0].srcid));
                chk("tgtid", 64'(req_tgtid), 64'(exp_q[0].tgtid));
                chk("last", 64'(req_last), 64'(exp_q[0].last));
                chk("qos", 64'(req_qos), 64'(1));
                if (req_ready) begin
                    o.cyc = cyc; o.srcid = req_srcid; o.tgtid = req_tgtid;
                    o.data = req_payload[PAYLOAD_WIDTH-1:CUSTOM_KEEP_WIDTH]; o.last = req_last;
                    flog.push_back(o);
                    void'(exp_q.pop_front());
                end
            end
            exp_rdy = '0;
            if (active < 0) begin
                found = 1'b0;
                if (!req_threshold && load) begin
                    for (int i = 0; i < NSRC; i++) begin
                        q = (mptr + i) % NSRC;
                        if (!found && s_valid[q]) begin
                            exp_rdy[q] = 1'b1;
                            found = 1'b1;
                        end
                    end
                end
            end else if (nb >= MAXB) begin
                exp_rdy[active] = 1'b1;
            end else begin
                exp_rdy[active] = load;
            end
            chk("s_ready", 64'(s_ready), 64'(exp_rdy));
            for (int p = 0; p < NSRC; p++) begin
                if (acc[p] && pq[p].size() != 0) model_accept(p, pq[p][0]);
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NSRC; p++) begin
            if (rst) begin
                if (sent[p] > 0) begin
                    while (pq[p].size() != 0) begin
                        b = pq[p].pop_front();
                        if (b.last) break;
                    end
                end
                sent[p] = 0;
                s_valid[p] = 1'b0;
            end else if (acc[p] && pq[p].size() != 0) begin
                b = pq[p].pop_front();
                sent[p] = b.last ? 0 : sent[p] + 1;
                s_valid[p] = 1'b0;
            end
            if (pq[p].size() == 0) begin
                s_valid[p] = 1'b0;
                s_data[p] = '0; s_keep[p] = '0; s_last[p] = 1'b0; s_tgtid[p] = '0;
            end else begin
                // Valid, once raised, is held until the beat is taken.
                if (!s_valid[p]) s_valid[p] = ($urandom_range(99) >= gap_pct);
                s_data[p]  = pq[p][0].data;
                s_keep[p]  = pq[p][0].keep;
                s_last[p]  = pq[p][0].last;
                s_tgtid[p] = pq[p][0].tgtid;
            end
        end
    endtask

    task automatic run_until_idle(input int max, input string nm);
        int n = 0;
        while (busy() && n < max) begin
            step();
            n++;
        end
        n_checks++;
        if (busy()) begin
            n_err++;
            $display("FAIL %s: timeout after %0d cycles, still busy", nm, max);
        end
    endtask

    task automatic clear_logs();
        flog.delete();
        glog_port.delete();
        glog_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; s_valid = '0; s_data = '0; s_keep = '0; s_last = '0; s_tgtid = '0;
        req_threshold = 1'b0; req_ready = 1'b1;
        for (int p = 0; p < NSRC; p++) sent[p] = 0;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_req_valid", 64'(req_valid), 64'(0));
        chk("reset_req_last", 64'(req_last), 64'(0));
        chk("reset_srcid", 64'(req_srcid), 64'(0));
        chk("reset_tgtid", 64'(req_tgtid), 64'(0));
        chk("reset_payload", 64'(req_payload), 64'(0));
        chk("reset_err_len", 64'(err_len), 64'(0));

        // Single 3-beat message on port 1.
        clear_logs();
        add_msg(1, 3, 32'h100, 1'b0);
        run_until_idle(20, "t1_idle");
        chk("t1_count", 64'(flog.size()), 64'(3));
        if (flog.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t1_srcid", 64'(flog[i].srcid), 64'(15));
                chk("t1_tgtid", 64'(flog[i].tgtid), 64'(1));
                chk("t1_data", 64'(flog[i].data), 64'(32'h100 + i));
                chk("t1_last", 64'(flog[i].last), 64'(i == 2));
                chk("t1_cycle", 64'(flog[i].cyc), 64'(glog_cyc[0] + 1 + i));
            end
        end

        // Ports 0 and 2 together after reset.
        rst = 1'b1; step(); rst = 1'b0;
        clear_logs();
        add_msg(0, 2, 32'h200, 1'b0);
        add_msg(2, 2, 32'h300, 1'b0);
        run_until_idle(20, "t2_idle");
        chk("t2_grants", 64'(glog_port.size()), 64'(2));
        if (glog_port.size() == 2) begin
            chk("t2_first", 64'(glog_port[0]), 64'(0));
            chk("t2_second", 64'(glog_port[1]), 64'(2));
        end
        if (flog.size() == 4) begin
            chk("t2_src0", 64'(flog[1].srcid), 64'(14));
            chk("t2_src2", 64'(flog[2].srcid), 64'(0));
            chk("t2_data", 64'(flog[2].data), 64'(32'h300));
        end else chk("t2_count", 64'(flog.size()), 64'(4));

        // Threshold blocks a new message, not one in flight.
        clear_logs();
        req_threshold = 1'b1;
        add_msg(3, 3, 32'h400, 1'b0);
        rdy_seen = 0;
        for (int i = 0; i < 10; i++) step();
        chk("t3_blocked", 64'(rdy_seen), 64'(0));
        req_threshold = 1'b0;
        n = 0;
        while (glog_port.size() == 0 && n < 5) begin step(); n++; end
        chk("t3_granted", 64'(glog_port.size()), 64'(1));
        req_threshold = 1'b1;
        run_until_idle(20, "t3_idle");
        req_threshold = 1'b0;
        chk("t3_count", 64'(flog.size()), 64'(3));
        if (flog.size() == 3) chk("t3_last", 64'(flog[2].last), 64'(1));

        // Downstream stalls every other cycle during a 4-beat message.
        clear_logs();
        add_msg(0, 4, 32'h500, 1'b0);
        for (int i = 0; i < 60 && busy(); i++) begin
            req_ready = (i % 2 == 0);
            step();
        end
        req_ready = 1'b1;
        chk("t4_count", 64'(flog.size()), 64'(4));
        if (flog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t4_data", 64'(flog[i].data), 64'(32'h500 + i));
                chk("t4_last", 64'(flog[i].last), 64'(i == 3));
            end
        end

        // 6-beat message truncated to 4, then port 2.
        clear_logs();
        err_seen = 0;
        add_msg(1, 6, 32'h600, 1'b0);
        add_msg(2, 1, 32'h700, 1'b0);
        run_until_idle(40, "t5_idle");
        chk("t5_count", 64'(flog.size()), 64'(5));
        chk("t5_err_pulses", 64'(err_seen), 64'(1));
        if (flog.size() == 5) begin
            chk("t5_beat3_data", 64'(flog[3].data), 64'(32'h603));
            chk("t5_beat3_last", 64'(flog[3].last), 64'(1));
            chk("t5_beat2_last", 64'(flog[2].last), 64'(0));
            chk("t5_next_src", 64'(flog[4].srcid), 64'(0));
            chk("t5_next_data", 64'(flog[4].data), 64'(32'h700));
        end

        // Reset while a flit is stalled; pointer returns to port 0.
        clear_logs();
        req_ready = 1'b0;
        add_msg(1, 3, 32'h800, 1'b0);
        n = 0;
        while (!req_valid && n < 10) begin step(); n++; end
        chk("t6_stalled", 64'(req_valid), 64'(1));
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_flush", 64'(req_valid), 64'(0));
        req_ready = 1'b1;
        clear_logs();
        add_msg(3, 1, 32'h900, 1'b0);
        add_msg(0, 1, 32'hA00, 1'b0);
        run_until_idle(20, "t6_idle");
        chk("t6_count", 64'(flog.size()), 64'(2));
        if (glog_port.size() == 2) chk("t6_first_port", 64'(glog_port[0]), 64'(0));
        if (flog.size() == 2) chk("t6_first_data", 64'(flog[0].data), 64'(32'hA00));

        // Randomized traffic with stalls, threshold and occasional reset.
        clear_logs();
        gap_pct = 30;
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < NSRC; p++) begin
                if (pq[p].size() < 10 && $urandom_range(7) == 0)
                    add_msg(p, $urandom_range(1, 7), 32'h0, 1'b1);
            end
            req_ready     = ($urandom_range(3) != 0);
            req_threshold = ($urandom_range(4) == 0);
            rst           = ($urandom_range(699) == 0);
            step();
            if (flog.size() > 64) clear_logs();
        end
        rst = 1'b0; req_threshold = 1'b0; req_ready = 1'b1; gap_pct = 0;
        run_until_idle(2000, "random_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
